// File: rtl/lif_seq.sv
// lif_seq: time-multiplexes one LIF neuron core over NUM_NEURONS BRAM membrane slots per timestep.
// Build option LIF_SEQ_SPK_COUNT_EN adds the spk_count output (spikes emitted in the current timestep).
module lif_seq #(
  parameter int NUM_NEURONS  = 64,
  parameter int ADDR_W       = 6,
  parameter int WIDTH        = 32,
  parameter int BRAM_LATENCY = 1,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    ts_done,
  output logic                    err,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd_en,
  input  logic signed [WIDTH-1:0] mem_rd_data,
  input  logic signed [WIDTH-1:0] cur_rd_data,
  output logic                    mem_wr_en,
  output logic signed [WIDTH-1:0] mem_wr_data,
  output logic                    lif_enable,
  output logic signed [WIDTH-1:0] lif_mem_in,
  output logic signed [WIDTH-1:0] lif_network_input,
  input  logic                    lif_spk_out,
  input  logic                    lif_done,
  input  logic signed [WIDTH-1:0] lif_mem_out,
  output logic                    spk_valid,
  output logic [ADDR_W-1:0]       spk_idx,
  output logic                    spk_val,
  output logic [2:0]              dbg_state
`ifdef LIF_SEQ_SPK_COUNT_EN
  ,
  output logic [ADDR_W:0]         spk_count
`endif
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, FIRE, WRITE, FIN} state_e;

  localparam int WCW = $clog2(BRAM_LATENCY + 1);
  localparam int FCW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(BRAM_LATENCY - 1);
  localparam logic [FCW-1:0]    FIRE_LAST = FCW'(DONE_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic [WCW-1:0]            wait_cnt_q, wait_cnt_d;
  logic [FCW-1:0]            fire_cnt_q, fire_cnt_d;
  logic signed [WIDTH-1:0]   op_mem_q, op_mem_d;
  logic signed [WIDTH-1:0]   op_cur_q, op_cur_d;
  logic signed [WIDTH-1:0]   res_mem_q, res_mem_d;
  logic                      res_spk_q, res_spk_d;
  logic                      err_q, err_d;

  // Neuron handshake: lif_enable is high only in FIRE with operands frozen; a cycle with
  // lif_done high completes the index. WRITE always drops enable, which clears the neuron.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    fire_cnt_d = fire_cnt_q;
    op_mem_d   = op_mem_q;
    op_cur_d   = op_cur_q;
    res_mem_d  = res_mem_q;
    res_spk_d  = res_spk_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          op_mem_d   = mem_rd_data;
          op_cur_d   = cur_rd_data;
          fire_cnt_d = '0;
          state_d    = FIRE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      FIRE: begin
        if (lif_done) begin
          res_mem_d = lif_mem_out;
          res_spk_d = lif_spk_out;
          state_d   = WRITE;
        end else if (fire_cnt_q == FIRE_LAST) begin
          // Stalled neuron: keep the old membrane and report no spike.
          err_d     = 1'b1;
          res_mem_d = op_mem_q;
          res_spk_d = 1'b0;
          state_d   = WRITE;
        end else begin
          fire_cnt_d = fire_cnt_q + FCW'(1);
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = READ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      fire_cnt_q <= '0;
      op_mem_q   <= '0;
      op_cur_q   <= '0;
      res_mem_q  <= '0;
      res_spk_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      fire_cnt_q <= fire_cnt_d;
      op_mem_q   <= op_mem_d;
      op_cur_q   <= op_cur_d;
      res_mem_q  <= res_mem_d;
      res_spk_q  <= res_spk_d;
      err_q      <= err_d;
    end
  end

  assign busy              = (state_q == READ) || (state_q == WAIT) ||
                             (state_q == FIRE) || (state_q == WRITE);
  assign ts_done           = (state_q == FIN);
  assign err               = err_q;
  assign mem_rd_en         = (state_q == READ);
  assign mem_wr_en         = (state_q == WRITE);
  assign mem_addr          = (mem_rd_en || mem_wr_en) ? idx_q : '0;
  assign mem_wr_data       = mem_wr_en ? res_mem_q : '0;
  assign lif_enable        = (state_q == FIRE);
  assign lif_mem_in        = op_mem_q;
  assign lif_network_input = op_cur_q;
  assign spk_valid         = mem_wr_en;
  assign spk_idx           = mem_wr_en ? idx_q : '0;
  assign spk_val           = mem_wr_en & res_spk_q;
  assign dbg_state         = state_q;

`ifdef LIF_SEQ_SPK_COUNT_EN
  localparam int CW = ADDR_W + 1;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
    end else if (state_q == WRITE && res_spk_q) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign spk_count = cnt_q;
`endif

endmodule
